// File: rtl/usbt_parse_fifo_arb.sv
// usbt_parse_fifo_arb: packet-atomic round-robin drain of several parse FIFOs
// into one registered entry stream, with a mid-packet stall watchdog.
module usbt_parse_fifo_arb #(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned WIDTH       = 43,
    parameter int unsigned STALL_WIDTH = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [STALL_WIDTH-1:0]       stall_limit,
    input  logic                         stall_err_clr,
    input  logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*WIDTH-1:0]     src_data,
    output logic [NUM_SRC-1:0]           src_read,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [1:0]                   out_src,
    output logic                         busy,
    output logic                         stall_err,
    output logic [1:0]                   stall_src,
    output logic [NUM_SRC*CNT_WIDTH-1:0] pkt_cnt
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned SUM_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       grant_next;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       last_grant_next;
    logic [STALL_WIDTH-1:0] stall_timer;
    logic [STALL_WIDTH-1:0] stall_timer_next;

    logic                   ready_sel;
    logic [WIDTH-1:0]       data_sel;
    logic                   found;
    logic [IDX_W-1:0]       pick;
    logic [SUM_W-1:0]       cand;
    logic                   cand_ready;
    logic                   stall_fire;
    logic                   pop;
    logic                   eop_pop;

    // Head entry and ready flag of the currently granted source
    always_comb begin
        ready_sel = 1'b0;
        data_sel  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant == IDX_W'(i)) begin
                ready_sel = src_ready[i];
                data_sel  = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin search starting one past the last granted source
    always_comb begin
        found      = 1'b0;
        pick       = last_grant;
        cand       = '0;
        cand_ready = 1'b0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = SUM_W'(last_grant) + SUM_W'(i);
            if (cand >= SUM_W'(NUM_SRC)) begin
                cand = cand - SUM_W'(NUM_SRC);
            end
            cand_ready = 1'b0;
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
                if (cand == SUM_W'(j)) begin
                    cand_ready = src_ready[j];
                end
            end
            if (!found && cand_ready) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
    end

    // Pop / stall decisions; a firing stall suppresses any pop that cycle
    always_comb begin
        stall_fire = (state == ACTIVE) && (stall_limit != '0) && (stall_timer >= stall_limit);
        pop        = (state == ACTIVE) && !stall_fire && ready_sel && (!out_valid || out_ready);
        eop_pop    = pop && data_sel[WIDTH-1];
    end

    // One-hot pop strobe toward the granted FIFO
    always_comb begin
        src_read = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_read[i] = pop && (grant == IDX_W'(i));
        end
    end

    // FSM state and arbitration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= IDX_W'(NUM_SRC - 1);
            stall_timer <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last_grant  <= last_grant_next;
            stall_timer <= stall_timer_next;
        end
    end

    // FSM next-state: grant in IDLE, hold the packet in ACTIVE until EOP or stall
    always_comb begin
        state_next       = state;
        grant_next       = grant;
        last_grant_next  = last_grant;
        stall_timer_next = stall_timer;
        case (state)
            IDLE: begin
                stall_timer_next = '0;
                if (enable && found) begin
                    grant_next = pick;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (pop) begin
                    stall_timer_next = '0;
                end else if (!ready_sel) begin
                    stall_timer_next = stall_timer + STALL_WIDTH'(1);
                end
                if (eop_pop || stall_fire) begin
                    state_next       = IDLE;
                    last_grant_next  = grant;
                    stall_timer_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == ACTIVE);

    // Registered output entry; holds while downstream backpressures
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= data_sel;
            out_src   <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky stall flag; clear wins over a simultaneous new stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_err <= 1'b0;
            stall_src <= '0;
        end else if (stall_err_clr) begin
            stall_err <= 1'b0;
            stall_src <= '0;
        end else if (stall_fire) begin
            stall_err <= 1'b1;
            if (!stall_err) begin
                stall_src <= grant;
            end
        end
    end

    // Per-source count of forwarded EOP entries, wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (eop_pop && (grant == IDX_W'(i))) begin
                    pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_usbt_parse_fifo_arb.sv
// Directed bench for usbt_parse_fifo_arb with a queue model of two parse FIFOs.
module tb_usbt_parse_fifo_arb;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] stall_limit;
    logic        stall_err_clr;
    logic [1:0]  src_ready;
    logic [85:0] src_data;
    logic [1:0]  src_read;
    logic        out_valid;
    logic        out_ready;
    logic [42:0] out_data;
    logic [1:0]  out_src;
    logic        busy;
    logic        stall_err;
    logic [1:0]  stall_src;
    logic [31:0] pkt_cnt;

    logic [42:0] q0[$];
    logic [42:0] q1[$];
    logic [1:0]  rx_src[$];
    logic [42:0] rx_data[$];
    logic [63:0] rd_hist;
    logic [1:0]  rd;
    logic [15:0] rx_src_pack;
    logic [42:0] exp2[8];
    int          n_tests;
    int          n_fail;

    usbt_parse_fifo_arb #(
        .NUM_SRC(2), .WIDTH(43), .STALL_WIDTH(16), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .stall_limit(stall_limit), .stall_err_clr(stall_err_clr),
        .src_ready(src_ready), .src_data(src_data), .src_read(src_read),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .busy(busy), .stall_err(stall_err),
        .stall_src(stall_src), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [42:0] ent(input logic eop, input logic [15:0] v);
        return {eop, 1'b0, 25'd0, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present FIFO heads to the DUT
    task automatic refresh();
        src_ready[0] = (q0.size() != 0);
        src_ready[1] = (q1.size() != 0);
        src_data[42:0]  = (q0.size() != 0) ? q0[0] : 43'd0;
        src_data[85:43] = (q1.size() != 0) ? q1[0] : 43'd0;
    endtask

    // One clock: sample pops/transfers at the negedge, apply them after the edge
    task automatic tick();
        @(negedge clk);
        rd = src_read;
        rd_hist = {rd_hist[61:0], rd};
        if (out_valid && out_ready) begin
            rx_src.push_back(out_src);
            rx_data.push_back(out_data);
        end
        @(posedge clk);
        #1;
        if (rd[0]) void'(q0.pop_front());
        if (rd[1]) void'(q1.pop_front());
        refresh();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        stall_limit = 16'd0;
        stall_err_clr = 1'b0;
        out_ready = 1'b1;
        rd_hist = '0;
        refresh();
        @(posedge clk);
        #1;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_stall_err", 64'(stall_err), 64'd0);
        check("rst_src_read", 64'(src_read), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Three-entry packet from source 0
        q0.push_back(ent(1'b0, 16'h11));
        q0.push_back(ent(1'b0, 16'h12));
        q0.push_back(ent(1'b1, 16'h13));
        refresh();
        enable = 1'b1;
        rd_hist = '0;
        rx_data.delete();
        rx_src.delete();
        tick();
        check("t1_busy_grant", 64'(busy), 64'd1);
        repeat (3) tick();
        check("t1_busy_after_eop", 64'(busy), 64'd0);
        check("t1_pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd1);
        repeat (2) tick();
        check("t1_read_seq", rd_hist, 64'h150);
        check("t1_rx_count", 64'(rx_data.size()), 64'd3);
        if (rx_data.size() == 3) begin
            check("t1_rx0", 64'(rx_data[0]), 64'(ent(1'b0, 16'h11)));
            check("t1_rx1", 64'(rx_data[1]), 64'(ent(1'b0, 16'h12)));
            check("t1_rx2", 64'(rx_data[2]), 64'(ent(1'b1, 16'h13)));
        end
        check("t1_out_valid_idle", 64'(out_valid), 64'd0);

        // Round robin over continuous two-entry packets
        do_reset();
        exp2[0] = ent(1'b0, 16'h20); exp2[1] = ent(1'b1, 16'h21);
        exp2[2] = ent(1'b0, 16'h30); exp2[3] = ent(1'b1, 16'h31);
        exp2[4] = ent(1'b0, 16'h22); exp2[5] = ent(1'b1, 16'h23);
        exp2[6] = ent(1'b0, 16'h32); exp2[7] = ent(1'b1, 16'h33);
        q0.push_back(exp2[0]); q0.push_back(exp2[1]);
        q0.push_back(exp2[4]); q0.push_back(exp2[5]);
        q1.push_back(exp2[2]); q1.push_back(exp2[3]);
        q1.push_back(exp2[6]); q1.push_back(exp2[7]);
        refresh();
        rd_hist = '0;
        rx_data.delete();
        rx_src.delete();
        repeat (12) tick();
        check("t2_read_seq", rd_hist, 64'h14A14A);
        repeat (2) tick();
        check("t2_rx_count", 64'(rx_data.size()), 64'd8);
        if (rx_data.size() == 8) begin
            rx_src_pack = '0;
            for (int i = 0; i < 8; i++) begin
                rx_src_pack = {rx_src_pack[13:0], rx_src[i]};
                check($sformatf("t2_rx%0d", i), 64'(rx_data[i]), 64'(exp2[i]));
            end
            check("t2_src_seq", 64'(rx_src_pack), 64'h0505);
        end
        check("t2_pkt_cnt", 64'(pkt_cnt), 64'h0002_0002);

        // Backpressure mid-packet
        q0.push_back(ent(1'b0, 16'h40));
        q0.push_back(ent(1'b0, 16'h41));
        q0.push_back(ent(1'b0, 16'h42));
        q0.push_back(ent(1'b1, 16'h43));
        refresh();
        rx_data.delete();
        rx_src.delete();
        repeat (3) tick();
        out_ready = 1'b0;
        rd_hist = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_hold_data%0d", i), 64'(out_data), 64'(ent(1'b0, 16'h41)));
            check($sformatf("t3_hold_valid%0d", i), 64'(out_valid), 64'd1);
        end
        check("t3_no_read", rd_hist, 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("t3_rx_count", 64'(rx_data.size()), 64'd4);
        if (rx_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_rx%0d", i), 64'(rx_data[i][15:0]), 64'(16'h40 + 16'(i)));
            end
        end

        // Stall watchdog on source 1
        stall_limit = 16'd5;
        q1.push_back(ent(1'b0, 16'h50));
        q0.push_back(ent(1'b1, 16'h60));
        refresh();
        rx_data.delete();
        rx_src.delete();
        repeat (7) tick();
        check("t4_no_stall_yet", 64'(stall_err), 64'd0);
        check("t4_busy_before", 64'(busy), 64'd1);
        tick();
        check("t4_stall_err", 64'(stall_err), 64'd1);
        check("t4_stall_src", 64'(stall_src), 64'd1);
        check("t4_idle_after", 64'(busy), 64'd0);
        rd_hist = '0;
        repeat (2) tick();
        check("t4_next_grant0", rd_hist, 64'h1);
        check("t4_rx_count", 64'(rx_data.size()), 64'd1);
        stall_err_clr = 1'b1;
        tick();
        stall_err_clr = 1'b0;
        check("t4_clr_err", 64'(stall_err), 64'd0);
        check("t4_clr_src", 64'(stall_src), 64'd0);
        stall_limit = 16'd0;

        // enable dropped mid-packet
        q0.push_back(ent(1'b0, 16'h70));
        q0.push_back(ent(1'b0, 16'h71));
        q0.push_back(ent(1'b0, 16'h72));
        q0.push_back(ent(1'b1, 16'h73));
        refresh();
        rx_data.delete();
        rx_src.delete();
        repeat (2) tick();
        enable = 1'b0;
        rd_hist = '0;
        repeat (3) tick();
        q0.push_back(ent(1'b0, 16'h80));
        refresh();
        repeat (4) tick();
        check("t5_read_seq", rd_hist, 64'h1500);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rx_count", 64'(rx_data.size()), 64'd4);
        if (rx_data.size() == 4) begin
            check("t5_rx_last", 64'(rx_data[3]), 64'(ent(1'b1, 16'h73)));
        end
        check("t5_pkt_cnt", 64'(pkt_cnt), 64'h0002_0005);

        // Async reset mid-packet
        q0.push_back(ent(1'b0, 16'h81));
        q0.push_back(ent(1'b1, 16'h82));
        refresh();
        enable = 1'b1;
        repeat (2) tick();
        check("t6_valid_before", 64'(out_valid), 64'd1);
        check("t6_busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        q1.push_back(ent(1'b1, 16'h90));
        refresh();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd_hist = '0;
        repeat (2) tick();
        check("t6_first_grant0", rd_hist, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usbt_parse_fifo_arb.md
# usbt_parse_fifo_arb

Packet-atomic round-robin scheduler that drains several parse FIFOs (one per USB parse instance, e.g. upstream and downstream parsers) into a single registered entry stream toward the CPU/DMA read path. It owns the FIFO read side: it issues pops, holds a grant for a whole packet until the entry carrying EOP, and detects sources that stall mid-packet.

## Interface
- NUM_SRC, 2: number of FIFO sources, 2..4.
- WIDTH, 43: FIFO entry width; bit WIDTH-1 is EOP, bit WIDTH-2 is error.
- STALL_WIDTH, 16: width of stall timer and stall_limit.
- CNT_WIDTH, 16: width of each per-source packet counter.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  arbitration enable; a granted packet always completes.
- stall_limit  in  STALL_WIDTH  max consecutive empty cycles mid-packet; 0 disables the watchdog.
- stall_err_clr  in  1  clears stall_err and stall_src.
- src_ready  in  NUM_SRC  per-source FIFO non-empty; the head entry is valid on src_data.
- src_data  in  NUM_SRC*WIDTH  head entries, source i at [i*WIDTH +: WIDTH].
- src_read  out  NUM_SRC  pop strobe; the head is consumed at the clock edge.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  output entry.
- out_src  out  2  source index of out_data.
- busy  out  1  high in ACTIVE.
- stall_err  out  1  sticky mid-packet stall flag.
- stall_src  out  2  source that caused the first stall since clear.
- pkt_cnt  out  NUM_SRC*CNT_WIDTH  per-source forwarded-EOP count, wrapping.

## Operation
- States: IDLE and ACTIVE. Registers: grant, last_grant (reset NUM_SRC-1), stall_timer.
- IDLE: if enable and any src_ready, set grant to the first ready source searching (last_grant+1) mod NUM_SRC upward, then go to ACTIVE. No pop happens in the IDLE cycle.
- ACTIVE pop condition: src_read[grant] = src_ready[grant] & (!out_valid | out_ready). This is combinational, including through out_ready. Only one bit of src_read is high at a time.
- On a pop: out_data <= src_data[grant], out_src <= grant, out_valid <= 1.
- If out_valid & out_ready and there is no pop, out_valid <= 0.
- If the popped entry has the EOP bit set: go to IDLE, last_grant <= grant, and pkt_cnt[grant] increments (wraps).
- enable is sampled only in IDLE. Deasserting enable mid-packet does not truncate the packet.
- Stall watchdog in ACTIVE:
  - stall_timer clears on every pop and increments when src_ready[grant] is low.
  - When stall_limit != 0 and stall_timer reaches stall_limit: go to IDLE, last_grant <= grant, stall_err <= 1.
  - stall_src loads only if stall_err was 0.
  - The partial packet is not terminated by this block; downstream detects the missing EOP.
- stall_err_clr has priority over a simultaneous new stall: the flag clears.
- A source dropping src_ready while not granted has no effect.

## Timing
- Reset values: all outputs and registers 0, except last_grant = NUM_SRC-1 (so source 0 wins first).
- Latency: src_read at edge N gives out_valid/out_data at N+1.
- Per-packet overhead is one IDLE grant cycle. Inside a packet, throughput is 1 entry/cycle when out_ready is held high.
- Backpressure: while out_valid & !out_ready, out_data and out_src stay stable and src_read is 0.
- Single-entry (EOP-only) packet: ACTIVE lasts exactly one cycle when its pop succeeds.
- EOP pop and a new request on the same cycle: the new grant is decided in the following IDLE cycle.
- A stall fires on the cycle stall_timer == stall_limit, i.e. after stall_limit empty cycles; the state is IDLE on the next cycle.
- Async reset mid-packet: everything returns to reset values and any held output entry is dropped.

## Test plan
- Source 0 holds 3 entries (EOP on the 3rd) and out_ready=1 -> src_read[0] high for 3 consecutive cycles after a 1-cycle grant; out_valid for 3 cycles; pkt_cnt[0]=1; busy low after the EOP.
- Both sources continuously hold 2-entry packets -> out_src sequence 0,0,1,1,0,0,1,1 with a one-cycle bubble between packets.
- Mid-packet out_ready low for 4 cycles -> out_data held constant, src_read 0 throughout, no entry lost or duplicated.
- stall_limit=5; source 1 empties after 1 of 3 entries -> stall_err=1 and stall_src=1 after 5 empty cycles; the next grant goes to source 0; stall_err_clr returns both to 0.
- enable dropped after the first of 4 entries -> all 4 forwarded, then IDLE with no new grant while enable=0.
- reset_n asserted with out_valid=1 in ACTIVE -> out_valid=0, busy=0, pkt_cnt=0 immediately; after release source 0 is granted first.
